// File: rtl/ex_muldiv.sv
// ex_muldiv -- iterative RISC-V M-extension execute unit (MUL/MULH/MULHSU/MULHU,
// DIV/DIVU/REM/REMU) sitting beside the single-cycle EX datapath.
//
// An operation is accepted from IDLE through valid_i/ready_o. Signed operands
// are reduced to magnitudes, an unsigned shift-add multiply or restoring
// shift-subtract divide retires UNROLL bits per edge, and the sign is
// re-applied on the final edge. Divide-by-zero and signed overflow are
// resolved directly at the accept edge. The result is held in DONE until
// writeback takes it through result_ready_i.
//
// Parameters:
//   XLEN   operand/result width (even, >= 8)
//   UNROLL bits retired per edge (1, 2 or 4, divides XLEN)
//   REG_AW destination tag width
//
// Ports:
//   clk_i, rst_n_i       clock (rising edge), asynchronous active-low reset
//   valid_i / ready_o    request handshake; ready_o is high only in IDLE
//   md_op_i              000 MUL 001 MULH 010 MULHSU 011 MULHU
//                        100 DIV 101 DIVU 110 REM    111 REMU
//   rA_i, rB_i, rd_i     operands and destination tag (sampled at accept only)
//   flush_i              synchronous kill of any in-flight operation
//   busy_o               high whenever the unit is not IDLE
//   valid_o, result_ready_i  result handshake
//   result_o, rd_o       result and its destination tag
module ex_muldiv #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [2:0]        md_op_i,
    input  logic [XLEN-1:0]   rA_i,
    input  logic [XLEN-1:0]   rB_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic              flush_i,
    output logic              busy_o,
    output logic              valid_o,
    input  logic              result_ready_i,
    output logic [XLEN-1:0]   result_o,
    output logic [REG_AW-1:0] rd_o
);

    localparam int N     = XLEN / UNROLL;
    localparam int CNT_W = $clog2(N + 1);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   result_q;
    logic [REG_AW-1:0] rd_q;

    // Iteration datapath. For multiply acc_q = {partial high, remaining
    // multiplier bits}; for divide acc_q = {partial remainder, dividend bits
    // being replaced by quotient bits}. opb_q is the multiplicand or divisor.
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   opb_q;
    logic [2:0]        op_q;
    logic              neg_q;

    // Accept-side decode
    logic              accept;
    logic              is_div;
    logic              a_sgn, b_sgn;
    logic              a_neg, b_neg;
    logic              res_neg;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic              div_zero, div_ovf, special;
    logic [XLEN-1:0]   special_res;
    logic [2*XLEN-1:0] acc_init;
    logic [XLEN-1:0]   opb_init;

    // Iteration-side results
    logic [2*XLEN-1:0] acc_nx;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   final_res;
    logic              last;

    // UNROLL radix-2 steps of either unsigned shift-add multiply or restoring
    // divide. In the divide branch the shifted remainder is one bit wider than
    // XLEN; when the subtraction fails its top bit is known to be zero, so
    // dropping it on the restore path loses nothing.
    function automatic logic [2*XLEN-1:0] step(input logic [2*XLEN-1:0] acc,
                                               input logic [XLEN-1:0]   opb,
                                               input logic              div);
        logic [XLEN:0]     t;
        logic [2*XLEN-1:0] a;
        a = acc;
        for (int i = 0; i < UNROLL; i++) begin
            if (div) begin
                t = a[2*XLEN-1:XLEN-1] - {1'b0, opb};
                if (!t[XLEN]) a = {t[XLEN-1:0], a[XLEN-2:0], 1'b1};
                else          a = {a[2*XLEN-2:0], 1'b0};
            end else begin
                t = {1'b0, a[2*XLEN-1:XLEN]} + (a[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
                a = {t, a[XLEN-1:1]};
            end
        end
        return a;
    endfunction

    function automatic logic [2*XLEN-1:0] fix_sign_w(input logic [2*XLEN-1:0] v,
                                                     input logic              neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [XLEN-1:0] fix_sign_x(input logic [XLEN-1:0] v,
                                                   input logic            neg);
        return neg ? -v : v;
    endfunction

    always_comb begin
        is_div = md_op_i[2];
        a_sgn  = (md_op_i == OP_MULH) || (md_op_i == OP_MULHSU) ||
                 (md_op_i == OP_DIV)  || (md_op_i == OP_REM);
        b_sgn  = (md_op_i == OP_MULH) || (md_op_i == OP_DIV) || (md_op_i == OP_REM);
        a_neg  = a_sgn & rA_i[XLEN-1];
        b_neg  = b_sgn & rB_i[XLEN-1];
        abs_a  = a_neg ? -rA_i : rA_i;
        abs_b  = b_neg ? -rB_i : rB_i;
        // Remainder follows the dividend; product and quotient follow the XOR.
        res_neg = (is_div && md_op_i[1]) ? a_neg : (a_neg ^ b_neg);

        div_zero = is_div && (rB_i == '0);
        div_ovf  = is_div && !md_op_i[0] && (rA_i == INT_MIN) && (&rB_i);
        special  = div_zero || div_ovf;

        special_res = '0;
        if (div_zero) special_res = md_op_i[1] ? rA_i : '1;
        else if (div_ovf) special_res = md_op_i[1] ? '0 : rA_i;

        acc_init = is_div ? {{XLEN{1'b0}}, abs_a} : {{XLEN{1'b0}}, abs_b};
        opb_init = is_div ? abs_b : abs_a;
    end

    always_comb begin
        acc_nx   = step(acc_q, opb_q, op_q[2]);
        prod_fix = fix_sign_w(acc_nx, neg_q);
        case (op_q)
            OP_MUL:                       final_res = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:               final_res = fix_sign_x(acc_nx[XLEN-1:0], neg_q);
            default:                      final_res = fix_sign_x(acc_nx[2*XLEN-1:XLEN], neg_q);
        endcase
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        if (flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        accept  = 1'b1;
                        state_d = special ? DONE : CALC;
                    end
                end
                CALC: begin
                    if (cnt_q == CNT_W'(1)) begin
                        last    = 1'b1;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (result_ready_i) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            rd_q     <= '0;
        end else begin
            state_q <= state_d;
            if (flush_i) begin
                cnt_q <= '0;
            end else if (accept) begin
                rd_q <= rd_i;
                if (special) begin
                    cnt_q    <= '0;
                    result_q <= special_res;
                end else begin
                    // The accept edge already retires the first UNROLL bits,
                    // so N-1 CALC edges remain.
                    cnt_q <= CNT_W'(N - 1);
                end
            end else if (state_q == CALC) begin
                cnt_q <= cnt_q - CNT_W'(1);
                if (last) result_q <= final_res;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            acc_q <= step(acc_init, opb_init, is_div);
            opb_q <= opb_init;
            op_q  <= md_op_i;
            neg_q <= res_neg;
        end else if (state_q == CALC) begin
            acc_q <= acc_nx;
        end
    end

    assign ready_o  = (state_q == IDLE);
    assign busy_o   = (state_q != IDLE);
    assign valid_o  = (state_q == DONE);
    assign result_o = result_q;
    assign rd_o     = rd_q;

endmodule
